// File: rtl/daq_frame_checker.sv
// rtl/daq_frame_checker.sv - ALCT DAQ frame parser with header, word-count and CRC-22 checks
module daq_frame_checker #(
    parameter int unsigned MAX_WORDS = 2047
) (
    input  logic        clk,
    input  logic        hard_rst,
    input  logic [18:0] daq_in,
    input  logic        cnt_clr,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [5:0]  err_flags,
    output logic [11:0] bxn_out,
    output logic [11:0] l1a_cnt_out,
    output logic [11:0] rd_cnt_out,
    output logic [3:0]  lct_bins_out,
    output logic [4:0]  raw_bins_out,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt,
    output logic        busy
);

    localparam logic [18:0] HDR_WORD = 19'h0DB0A;
    localparam logic [18:0] EOB_WORD = 19'h0DE0D;
    localparam logic [7:0]  TRL_TAG  = 8'b00111010;
    localparam logic [10:0] MAX_WC   = 11'(MAX_WORDS);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_BODY, S_CRCA, S_CRCB, S_TRL} state_t;

    state_t      state_q, state_d;
    logic [10:0] wcnt_q, wcnt_d, wcnt_inc;
    logic [21:0] crc_q, crc_d;
    logic [10:0] rxa_q, rxa_d, rxb_q, rxb_d;
    logic        hdr_acc_q, hdr_acc_d;
    logic [11:0] sh_bxn_q, sh_bxn_d, sh_l1a_q, sh_l1a_d, sh_rd_q, sh_rd_d;
    logic [3:0]  sh_lct_q, sh_lct_d;
    logic [4:0]  sh_raw_q, sh_raw_d;
    logic [11:0] last_rd_q;
    logic        last_vld_q;
    logic        close, trl_close, close_ok;
    logic [5:0]  err_d;

    // Serial CRC-22 (x^22 + x + 1), LSB-first over the 16 low payload bits
    function automatic logic [21:0] crc_next(input logic [21:0] c, input logic [15:0] d);
        logic [21:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 16; i++) begin
            fb = r[21] ^ d[i];
            r  = {r[20:0], 1'b0} ^ {20'b0, fb, fb};
        end
        return r;
    endfunction

    assign wcnt_inc = wcnt_q + 11'd1;
    assign close_ok = (err_d == 6'b0);

    // Frame parser: next state, shadow capture and close/error decode
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        crc_d     = crc_q;
        rxa_d     = rxa_q;
        rxb_d     = rxb_q;
        hdr_acc_d = hdr_acc_q;
        sh_bxn_d  = sh_bxn_q;
        sh_l1a_d  = sh_l1a_q;
        sh_rd_d   = sh_rd_q;
        sh_lct_d  = sh_lct_q;
        sh_raw_d  = sh_raw_q;
        close     = 1'b0;
        trl_close = 1'b0;
        err_d     = 6'b0;
        if (state_q == S_IDLE) begin
            if (daq_in == HDR_WORD) begin
                state_d   = S_HDR;
                wcnt_d    = 11'd1;
                crc_d     = crc_next(22'b0, daq_in[15:0]);
                hdr_acc_d = 1'b0;
            end
        end else if (daq_in[18]) begin
            close   = 1'b1;
            err_d   = {2'b00, 1'b1, hdr_acc_q, 2'b00};
            state_d = S_IDLE;
        end else if (daq_in == HDR_WORD && (state_q == S_HDR || state_q == S_BODY)) begin
            // Close the broken frame and reuse this word as the next header
            close     = 1'b1;
            err_d     = 6'b000100;
            state_d   = S_HDR;
            wcnt_d    = 11'd1;
            crc_d     = crc_next(22'b0, daq_in[15:0]);
            hdr_acc_d = 1'b0;
        end else if (state_q != S_TRL && wcnt_inc >= MAX_WC) begin
            close   = 1'b1;
            err_d   = {2'b01, 1'b0, hdr_acc_q, 2'b00};
            state_d = S_IDLE;
        end else begin
            wcnt_d = wcnt_inc;
            case (state_q)
                S_HDR: begin
                    crc_d = crc_next(crc_q, daq_in[15:0]);
                    if (wcnt_q <= 11'd3 && daq_in[18:12] != 7'h0D) hdr_acc_d = 1'b1;
                    if (wcnt_q == 11'd1) sh_bxn_d = daq_in[11:0];
                    if (wcnt_q == 11'd2) sh_l1a_d = daq_in[11:0];
                    if (wcnt_q == 11'd3) sh_rd_d  = daq_in[11:0];
                    if (wcnt_q == 11'd6) begin
                        sh_lct_d = daq_in[8:5];
                        sh_raw_d = daq_in[4:0];
                        state_d  = S_BODY;
                    end
                end
                S_BODY: begin
                    crc_d = crc_next(crc_q, daq_in[15:0]);
                    if (daq_in == EOB_WORD) state_d = S_CRCA;
                end
                S_CRCA: begin
                    rxa_d   = daq_in[10:0];
                    state_d = S_CRCB;
                end
                S_CRCB: begin
                    rxb_d   = daq_in[10:0];
                    state_d = S_TRL;
                end
                S_TRL: begin
                    close     = 1'b1;
                    trl_close = 1'b1;
                    err_d[0]  = ({rxb_q, rxa_q} != crc_q);
                    err_d[1]  = (daq_in[18:11] != TRL_TAG) || (daq_in[10:0] != wcnt_inc);
                    err_d[2]  = hdr_acc_q;
                    err_d[5]  = last_vld_q && (sh_rd_q != last_rd_q + 12'd1);
                    state_d   = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Parser state and per-frame working registers
    always_ff @(posedge clk or negedge hard_rst) begin
        if (!hard_rst) begin
            state_q   <= S_IDLE;
            wcnt_q    <= 11'd0;
            crc_q     <= 22'd0;
            rxa_q     <= 11'd0;
            rxb_q     <= 11'd0;
            hdr_acc_q <= 1'b0;
            sh_bxn_q  <= 12'd0;
            sh_l1a_q  <= 12'd0;
            sh_rd_q   <= 12'd0;
            sh_lct_q  <= 4'd0;
            sh_raw_q  <= 5'd0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            crc_q     <= crc_d;
            rxa_q     <= rxa_d;
            rxb_q     <= rxb_d;
            hdr_acc_q <= hdr_acc_d;
            sh_bxn_q  <= sh_bxn_d;
            sh_l1a_q  <= sh_l1a_d;
            sh_rd_q   <= sh_rd_d;
            sh_lct_q  <= sh_lct_d;
            sh_raw_q  <= sh_raw_d;
        end
    end

    // Close reporting, field publication, sequence tracking and counters
    always_ff @(posedge clk or negedge hard_rst) begin
        if (!hard_rst) begin
            frame_done   <= 1'b0;
            frame_ok     <= 1'b0;
            err_flags    <= 6'd0;
            bxn_out      <= 12'd0;
            l1a_cnt_out  <= 12'd0;
            rd_cnt_out   <= 12'd0;
            lct_bins_out <= 4'd0;
            raw_bins_out <= 5'd0;
            good_cnt     <= 16'd0;
            bad_cnt      <= 16'd0;
            busy         <= 1'b0;
            last_rd_q    <= 12'd0;
            last_vld_q   <= 1'b0;
        end else begin
            frame_done <= close;
            busy       <= (state_d != S_IDLE);
            if (close) begin
                frame_ok  <= close_ok;
                err_flags <= err_d;
                if (close_ok) begin
                    bxn_out      <= sh_bxn_q;
                    l1a_cnt_out  <= sh_l1a_q;
                    rd_cnt_out   <= sh_rd_q;
                    lct_bins_out <= sh_lct_q;
                    raw_bins_out <= sh_raw_q;
                end
            end
            if (trl_close) last_rd_q <= sh_rd_q;
            if (cnt_clr) begin
                good_cnt   <= 16'd0;
                bad_cnt    <= 16'd0;
                last_vld_q <= 1'b0;
            end else begin
                if (trl_close) last_vld_q <= 1'b1;
                if (close && close_ok && good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
                if (close && !close_ok && bad_cnt != 16'hFFFF) bad_cnt <= bad_cnt + 16'd1;
            end
        end
    end

endmodule
